// File: rtl/result_readout_seq_pkg.sv
// result_readout_seq_pkg: shared widths, core input-mode codes and readout FSM encodings.
package result_readout_seq_pkg;
    localparam int WORD_SIZE        = 16;
    localparam int RAM_ADDR_SIZE    = 8;
    localparam int I_INPUTMODE_SIZE = 3;
    localparam logic [I_INPUTMODE_SIZE-1:0] INPUT_COORD_CORE = 3'd0;
    localparam logic [I_INPUTMODE_SIZE-1:0] REF_RESULT       = 3'd5;
    localparam logic [RAM_ADDR_SIZE-1:0]    RAM_P_BT_0       = 8'h10;
    localparam int RR_NWORDS   = 24;
    localparam int RR_READ_LAT = 3;
    typedef enum logic [2:0] {
        RR_IDLE,
        RR_WAITC,
        RR_ISSUE,
        RR_WAIT,
        RR_CAP,
        RR_STREAM,
        RR_FIN
    } rr_state_e;
endpackage

// File: rtl/result_readout_seq_capture_buf.sv
// result_capture_buf: snapshot of one result entry, loaded all at once and read word by word.
module result_capture_buf #(
    parameter int NWORDS = 24,
    parameter int WORD_W = 16
) (
    input  logic                     clk,
    input  logic                     cap_en_i,
    input  logic [NWORDS*WORD_W-1:0] data_flat_i,
    input  logic [4:0]               idx_i,
    output logic [WORD_W-1:0]        rd_data_o
);
    logic [WORD_W-1:0] mem_q [NWORDS];

    // No reset: contents are only meaningful after a capture.
    always_ff @(posedge clk) begin
        if (cap_en_i) begin
            for (int i = 0; i < NWORDS; i++) mem_q[i] <= data_flat_i[i*WORD_W +: WORD_W];
        end
    end

    assign rd_data_o = mem_q[idx_i];
endmodule

// File: rtl/result_readout_seq.sv
// result_readout_seq: reads a run of result RAM entries once the core is idle and streams
// each entry out as 24 words over a valid/ready port.
module result_readout_seq
    import result_readout_seq_pkg::*;
#(
    parameter int WORD_W   = WORD_SIZE,
    parameter int ADDR_W   = RAM_ADDR_SIZE,
    parameter int MODE_W   = I_INPUTMODE_SIZE,
    parameter int NWORDS   = RR_NWORDS,
    parameter int READ_LAT = RR_READ_LAT,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_raddr,
    input  logic [CNT_W-1:0]         num_entries,
    input  logic                     core_busy,
    output logic [MODE_W-1:0]        o_inputmode,
    output logic [ADDR_W-1:0]        o_raddr,
    input  logic [NWORDS*WORD_W-1:0] result_flat,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WORD_W-1:0]        m_data,
    output logic [4:0]               m_idx,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done
);
    localparam int LAT_W = $clog2(READ_LAT) + 1;

    rr_state_e         state_q;
    logic [ADDR_W-1:0] base_q, raddr_q;
    logic [CNT_W-1:0]  cnt_q, k_q;
    logic [LAT_W-1:0]  lat_q;
    logic [4:0]        idx_q;
    logic [MODE_W-1:0] mode_q;
    logic              valid_q, done_q;
    logic              hs, last_word, last_entry;

    assign hs         = valid_q & m_ready;
    assign last_word  = idx_q == 5'(NWORDS - 1);
    assign last_entry = k_q == cnt_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RR_IDLE;
            mode_q  <= MODE_W'(INPUT_COORD_CORE);
            raddr_q <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RR_IDLE: if (start) begin
                    base_q  <= base_raddr;
                    cnt_q   <= num_entries;
                    k_q     <= '0;
                    done_q  <= num_entries == '0;
                    state_q <= num_entries == '0 ? RR_FIN : RR_WAITC;
                end
                RR_WAITC: if (!core_busy) state_q <= RR_ISSUE;
                RR_ISSUE: begin
                    mode_q  <= MODE_W'(REF_RESULT);
                    raddr_q <= base_q + ADDR_W'(k_q);
                    lat_q   <= LAT_W'(READ_LAT - 1);
                    state_q <= RR_WAIT;
                end
                RR_WAIT: begin
                    lat_q   <= lat_q - 1'b1;
                    state_q <= lat_q == '0 ? RR_CAP : RR_WAIT;
                end
                RR_CAP: begin
                    idx_q   <= '0;
                    valid_q <= 1'b1;
                    state_q <= RR_STREAM;
                end
                RR_STREAM: if (hs) begin
                    // Next entry goes straight to ISSUE: the core stays idle for the whole run.
                    if (last_word) begin
                        valid_q <= 1'b0;
                        k_q     <= k_q + 1'b1;
                        done_q  <= last_entry;
                        state_q <= last_entry ? RR_FIN : RR_ISSUE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                RR_FIN: begin
                    mode_q  <= MODE_W'(INPUT_COORD_CORE);
                    state_q <= RR_IDLE;
                end
                default: state_q <= RR_IDLE;
            endcase
        end
    end

    result_capture_buf #(.NWORDS(NWORDS), .WORD_W(WORD_W)) u_buf (
        .clk         (clk),
        .cap_en_i    (state_q == RR_CAP),
        .data_flat_i (result_flat),
        .idx_i       (idx_q),
        .rd_data_o   (m_data)
    );

    assign o_inputmode = mode_q;
    assign o_raddr     = raddr_q;
    assign m_valid     = valid_q;
    assign m_idx       = idx_q;
    assign m_last      = valid_q & last_word & last_entry;
    assign busy        = state_q != RR_IDLE;
    assign done        = done_q;
endmodule

// File: tb/tb_result_readout_seq.sv
// tb_result_readout_seq: directed bench with a 3-cycle-latency result RAM model returning {addr,w}.
module tb_result_readout_seq;
    import result_readout_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   base_raddr = '0;
    logic [7:0]   num_entries = '0;
    logic         core_busy = 1'b0;
    logic [2:0]   o_inputmode;
    logic [7:0]   o_raddr;
    logic [383:0] result_flat;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [15:0]  m_data;
    logic [4:0]   m_idx;
    logic         m_last;
    logic         busy;
    logic         done;
    logic [7:0]   a1, a2, a3;
    int           n_assert = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    result_readout_seq dut (
        .clk(clk), .rst(rst), .start(start), .base_raddr(base_raddr),
        .num_entries(num_entries), .core_busy(core_busy), .o_inputmode(o_inputmode),
        .o_raddr(o_raddr), .result_flat(result_flat), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_idx(m_idx), .m_last(m_last), .busy(busy), .done(done)
    );

    always_ff @(posedge clk) begin
        a1 <= o_raddr;
        a2 <= a1;
        a3 <= a2;
    end

    always_comb begin
        result_flat = '0;
        for (int w = 0; w < 24; w++) result_flat[w*16 +: 16] = {a3, 8'(w)};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] base, input logic [7:0] cnt,
                       input bit toggle, input int bcyc, input int exp_done);
        int          cyc, beat, done_at, rv;
        bit          stalled;
        logic [15:0] sd;
        logic [4:0]  si;
        logic        sl;
        logic [7:0]  raddr0, ea;
        rv = (bcyc < 1 ? 1 : bcyc) + 2;
        @(negedge clk);
        raddr0 = o_raddr;
        base_raddr = base;
        num_entries = cnt;
        start = 1'b1;
        core_busy = bcyc > 0;
        m_ready = 1'b1;
        cyc = 0;
        beat = 0;
        done_at = -1;
        stalled = 0;
        sd = '0;
        si = '0;
        sl = 1'b0;
        while (done_at < 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            core_busy = cyc < bcyc;
            m_ready = !toggle || cyc % 4 == 0 || cyc % 4 == 3;
            #1;
            if (cnt != 0 && cyc < rv) begin
                chk({tag, "_raddr_hold"}, o_raddr, raddr0);
                chk({tag, "_mode_hold"}, o_inputmode, INPUT_COORD_CORE);
            end else if (cnt != 0 && cyc == rv) begin
                chk({tag, "_raddr_issue"}, o_raddr, base);
                chk({tag, "_mode_ref"}, o_inputmode, REF_RESULT);
            end
            if (stalled) begin
                chk({tag, "_stall_valid"}, m_valid, 1'b1);
                chk({tag, "_stall_data"}, m_data, sd);
                chk({tag, "_stall_idx"}, m_idx, si);
                chk({tag, "_stall_last"}, m_last, sl);
            end
            if (m_valid && m_ready) begin
                ea = base + 8'(beat / 24);
                chk({tag, "_data"}, m_data, {ea, 8'(beat % 24)});
                chk({tag, "_idx"}, m_idx, beat % 24);
                chk({tag, "_last"}, m_last, beat == 24 * cnt - 1);
                beat++;
                stalled = 0;
            end else if (m_valid) begin
                stalled = 1;
                sd = m_data;
                si = m_idx;
                sl = m_last;
            end else begin
                stalled = 0;
                chk({tag, "_last_idle"}, m_last, 1'b0);
            end
            if (done) done_at = cyc;
        end
        chk({tag, "_done_seen"}, done_at >= 0, 1'b1);
        chk({tag, "_beats"}, beat, 24 * cnt);
        if (exp_done >= 0) chk({tag, "_done_cycle"}, done_at, exp_done);
        if (cnt == 0) chk({tag, "_raddr_kept"}, o_raddr, raddr0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_mode_end"}, o_inputmode, INPUT_COORD_CORE);
        chk({tag, "_valid_end"}, m_valid, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mode", o_inputmode, INPUT_COORD_CORE);
        chk("rst_raddr", o_raddr, 8'h00);
        chk("rst_idx", m_idx, 5'd0);
        chk("rst_last", m_last, 1'b0);

        run("single", RAM_P_BT_0, 8'd1, 1'b0, 0, 31);
        run("busy", 8'h40, 8'd1, 1'b0, 10, 40);
        run("stall", 8'h20, 8'd3, 1'b1, 0, -1);
        run("wrap", 8'hFF, 8'd2, 1'b0, 0, 60);
        run("empty", 8'h77, 8'd0, 1'b0, 0, 1);

        @(negedge clk);
        base_raddr = 8'h30;
        num_entries = 8'd1;
        start = 1'b1;
        m_ready = 1'b1;
        core_busy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !(m_valid && m_idx == 5'd7); i++) @(negedge clk);
        chk("abort_reach_idx", m_idx, 5'd7);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_valid", m_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_mode", o_inputmode, INPUT_COORD_CORE);
        chk("abort_done", done, 1'b0);
        rst = 1'b0;
        run("restart", 8'h50, 8'd1, 1'b0, 0, 31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
